noc_endpoint_tg: RTL

//  Synthesisable traffic generator/checker attached to one router P-port of an

---
 rtl/noc_endpoint_tg.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/noc_endpoint_tg.sv
// noc_endpoint_tg: per-router traffic generator/checker for a switch_router_dsb mesh.
// Define TG_TIMEOUT_EN to build the REQ/RTZ watchdog; otherwise timeout is tied 0.
module noc_endpoint_tg #(
    parameter int FLIT_W      = 32,
    parameter int COORD_W     = 3,
    parameter int SEQ_W       = 16,
    parameter int MESH_X      = 2,
    parameter int MESH_Y      = 2,
    parameter int TX_GAP      = 2,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] lx,
    input  logic [COORD_W-1:0] ly,
    input  logic               en,
    input  logic               dst_mode,
    input  logic [COORD_W-1:0] dst_x,
    input  logic [COORD_W-1:0] dst_y,
    input  logic [CNT_W-1:0]   num_flits,
    output logic [FLIT_W-1:0]  tx_dataout,
    output logic               tx_reqout,
    input  logic               tx_ackin,
    input  logic [FLIT_W-1:0]  rx_datain,
    input  logic               rx_reqin,
    output logic               rx_ackout,
    output logic [CNT_W-1:0]   tx_count,
    output logic [CNT_W-1:0]   rx_count,
    output logic [CNT_W-1:0]   err_count,
    output logic               done,
    output logic               timeout
);
    localparam logic [1:0] TX_IDLE = 2'd0, TX_GAPS = 2'd1, TX_REQ = 2'd2, TX_RTZ = 2'd3;
    localparam logic RX_IDLE = 1'b0, RX_ACK = 1'b1;
    localparam int NODES = MESH_X * MESH_Y;
    localparam int IDX_W = NODES > 1 ? $clog2(NODES) : 1;
    localparam int GAP_W = TX_GAP > 1 ? $clog2(TX_GAP) : 1;

    logic [1:0]           r_tx_st, w_tx_nxt;
    logic [GAP_W-1:0]     r_gap;
    logic [FLIT_W-1:0]    r_tx_data, w_flit;
    logic [CNT_W-1:0]     r_tx_cnt, r_rx_cnt, r_err_cnt;
    logic [2*COORD_W-1:0] r_ptr, w_ptr_eff, w_dst, w_own;
    logic                 r_done, r_rx_st;
    logic [SEQ_W-1:0]     r_exp [NODES];
    logic [COORD_W-1:0]   w_rdx, w_rdy, w_rsx, w_rsy;
    logic [SEQ_W-1:0]     w_rseq;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_src_out, w_err;

    // Sweep order: y fastest, then x, wrapping at the mesh edge.
    function automatic logic [2*COORD_W-1:0] f_inc(input logic [2*COORD_W-1:0] p);
        logic [COORD_W-1:0] x, y;
        x = p[2*COORD_W-1 -: COORD_W];
        y = p[COORD_W-1:0];
        if (y == COORD_W'(MESH_Y - 1))
            return {(x == COORD_W'(MESH_X - 1)) ? COORD_W'(0) : x + COORD_W'(1), COORD_W'(0)};
        return {x, y + COORD_W'(1)};
    endfunction

    assign w_own     = {lx, ly};
    assign w_ptr_eff = (r_ptr == w_own) ? f_inc(r_ptr) : r_ptr;
    assign w_dst     = dst_mode ? w_ptr_eff : {dst_x, dst_y};

    always_comb begin
        w_flit = '0;
        w_flit[FLIT_W-1 -: 4*COORD_W] = {w_dst, w_own};
        w_flit[SEQ_W-1:0] = SEQ_W'(r_tx_cnt);
    end

    always_comb begin
        w_tx_nxt = r_tx_st;
        case (r_tx_st)
            TX_IDLE: if (en && r_tx_cnt < num_flits) w_tx_nxt = (TX_GAP == 0) ? TX_REQ : TX_GAPS;
            TX_GAPS: if (int'(r_gap) >= TX_GAP - 1) w_tx_nxt = TX_REQ;
            TX_REQ:  if (tx_ackin) w_tx_nxt = TX_RTZ;
            default: if (!tx_ackin) w_tx_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_st   <= TX_IDLE;
            r_gap     <= '0;
            r_tx_data <= '0;
            r_tx_cnt  <= '0;
            r_ptr     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_tx_st <= w_tx_nxt;
            r_gap   <= (r_tx_st == TX_GAPS) ? r_gap + GAP_W'(1) : '0;
            r_done  <= (r_tx_st == TX_IDLE) && (r_tx_cnt >= num_flits);
            if (w_tx_nxt == TX_REQ && r_tx_st != TX_REQ)
                r_tx_data <= w_flit;
            if (r_tx_st == TX_REQ && tx_ackin) begin
                r_tx_cnt <= r_tx_cnt + CNT_W'(r_tx_cnt != '1);
                if (dst_mode)
                    r_ptr <= f_inc(w_ptr_eff);
            end
        end
    end

    assign w_rdx  = rx_datain[FLIT_W-1 -: COORD_W];
    assign w_rdy  = rx_datain[FLIT_W-1-COORD_W -: COORD_W];
    assign w_rsx  = rx_datain[FLIT_W-1-2*COORD_W -: COORD_W];
    assign w_rsy  = rx_datain[FLIT_W-1-3*COORD_W -: COORD_W];
    assign w_rseq = rx_datain[SEQ_W-1:0];
    assign w_src_out = (int'(w_rsx) >= MESH_X) || (int'(w_rsy) >= MESH_Y);
    assign w_idx  = IDX_W'(int'(w_rsx) * MESH_Y + int'(w_rsy));
    assign w_err  = ({w_rdx, w_rdy} != w_own) || w_src_out || (w_rseq != r_exp[w_idx]);

    // The expected-seq entry always resyncs to the received seq, so one gap costs one error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_st   <= RX_IDLE;
            r_rx_cnt  <= '0;
            r_err_cnt <= '0;
            for (int i = 0; i < NODES; i++) r_exp[i] <= '0;
        end else if (r_rx_st == RX_IDLE && rx_reqin) begin
            r_rx_st  <= RX_ACK;
            r_rx_cnt <= r_rx_cnt + CNT_W'(r_rx_cnt != '1);
            if (w_err)
                r_err_cnt <= r_err_cnt + CNT_W'(r_err_cnt != '1);
            if (!w_src_out)
                r_exp[w_idx] <= w_rseq + SEQ_W'(1);
        end else if (r_rx_st == RX_ACK && !rx_reqin) begin
            r_rx_st <= RX_IDLE;
        end
    end

`ifdef TG_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] r_to_cnt, w_to_nxt;
    logic            r_timeout;
    assign w_to_nxt = (w_tx_nxt != r_tx_st || !r_tx_st[1]) ? '0 :
                      r_to_cnt + TO_W'(r_to_cnt != TO_W'(TIMEOUT_CYC));
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_to_cnt  <= w_to_nxt;
            r_timeout <= r_timeout | (w_to_nxt == TO_W'(TIMEOUT_CYC));
        end
    end
    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

    assign tx_dataout = r_tx_data;
    assign tx_reqout  = (r_tx_st == TX_REQ);
    assign rx_ackout  = (r_rx_st == RX_ACK);
    assign tx_count   = r_tx_cnt;
    assign rx_count   = r_rx_cnt;
    assign err_count  = r_err_cnt;
    assign done       = r_done;
endmodule
